// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int BYTE_W        = 8;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_ISSUE       = 2'd1,
        S_WAIT_ACTIVE = 2'd2,
        S_WAIT_DONE   = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Producer push port, queue status and transmitter handshake for uart_tx_queue.
// Latency: wires only.
// Backpressure: producers watch o_Full; the transmitter side is a DV/Active/Done handshake.
interface uart_tx_queue_if #(
    parameter int DEPTH = uart_pkg::DEFAULT_DEPTH
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              i_Wr_En;
    logic [7:0]        i_Wr_Byte;
    logic              o_Full;
    logic              o_Empty;
    logic [ADDR_W:0]   o_Level;
    logic              o_Tx_DV;
    logic [7:0]        o_Tx_Byte;
    logic              i_Tx_Active;
    logic              i_Tx_Done;
    logic              o_Busy;
    logic              i_Ovf_Clr;
    logic              o_Overflow;

    modport slave (
        input  i_Wr_En, i_Wr_Byte, i_Tx_Active, i_Tx_Done, i_Ovf_Clr,
        output o_Full, o_Empty, o_Level, o_Tx_DV, o_Tx_Byte, o_Busy, o_Overflow
    );

    modport master (
        output i_Wr_En, i_Wr_Byte, i_Tx_Active, i_Tx_Done, i_Ovf_Clr,
        input  o_Full, o_Empty, o_Level, o_Tx_DV, o_Tx_Byte, o_Busy, o_Overflow
    );

endinterface

// File: rtl/uart_tx_queue_mem.sv
// DEPTH x 8 byte storage: synchronous write, asynchronous read, no reset.
// Latency: write visible one edge after we; read is combinational.
// Backpressure: none; the caller guards writes against a full queue.
module uart_tx_queue_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter one byte at a time; UART_TX_QUEUE_OVF_EN enables the sticky overflow flag.
// Latency: push into empty queue at edge N gives o_Tx_DV during N+1..N+2; next issue 2 cycles after i_Tx_Done.
// Backpressure: pushes while o_Full are dropped; one byte outstanding at the transmitter at a time.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic      i_Clock,
    input  logic      i_Reset_n,
    uart_tx_queue_if.slave bus
);

    localparam int                ADDR_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    tx_state_e         state_q, state_d;
    logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
    logic [BYTE_W-1:0] head_byte;
    logic              full, empty, push, pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    // Acceptance looks only at the registered full flag, so a same-cycle pop never rescues a push.
    assign push  = bus.i_Wr_En && !full;
    assign pop   = (state_q == S_IDLE) && !empty;

    uart_tx_queue_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (i_Clock),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (bus.i_Wr_Byte),
        .raddr (rd_ptr_q),
        .rdata (head_byte)
    );

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d   = S_ISSUE;
                    tx_byte_d = head_byte;
                end
            end
            S_ISSUE:       state_d = S_WAIT_ACTIVE;
            // A short byte may finish before Active is ever sampled.
            S_WAIT_ACTIVE: begin
                if (bus.i_Tx_Done)        state_d = S_IDLE;
                else if (bus.i_Tx_Active) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.i_Tx_Done) state_d = S_IDLE;
            end
            default:       state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            tx_byte_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    assign bus.o_Full    = full;
    assign bus.o_Empty   = empty;
    assign bus.o_Level   = count_q;
    assign bus.o_Tx_DV   = (state_q == S_ISSUE);
    assign bus.o_Tx_Byte = tx_byte_q;
    assign bus.o_Busy    = (state_q != S_IDLE) || !empty;

`ifdef UART_TX_QUEUE_OVF_EN
    logic ovf_q, ovf_d;
    logic drop;

    assign drop = bus.i_Wr_En && full;

    always_comb begin
        ovf_d = ovf_q;
        if (bus.i_Ovf_Clr) ovf_d = 1'b0;
        if (drop)          ovf_d = 1'b1;
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) ovf_q <= 1'b0;
        else            ovf_q <= ovf_d;
    end

    assign bus.o_Overflow = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = bus.i_Ovf_Clr;
    assign bus.o_Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a transmitter model and a byte-order scoreboard.
module tb_uart_tx_queue;
    import uart_pkg::*;

    localparam int DEPTH = 16;
`ifdef UART_TX_QUEUE_OVF_EN
    localparam int OVF_ON = 1;
`else
    localparam int OVF_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] exp_q [$];
    int dv_cnt = 0;
    int last_dv_cyc = -1;
    int done_cyc = -1;
    bit gap_pending = 1'b0;
    int tx_len = 10;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every issue must match the oldest accepted byte.
    always @(negedge clk) begin
        if (rst_n && bus.o_Tx_DV) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: byte %0h issued with nothing queued (cycle %0d)", bus.o_Tx_Byte, cyc);
            end else begin
                chk("issue_byte", bus.o_Tx_Byte, exp_q.pop_front());
            end
            if (gap_pending) begin
                chk("done_to_dv_gap", cyc - done_cyc, 2);
                gap_pending = 1'b0;
            end
            dv_cnt++;
            last_dv_cyc = cyc;
        end
    end

    // Transmitter model: Active one cycle after DV for tx_len cycles, then a Done pulse.
    initial begin
        bus.i_Tx_Active = 1'b0;
        bus.i_Tx_Done   = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_Tx_DV) begin
                @(posedge clk);
                #1 bus.i_Tx_Active = 1'b1;
                repeat (tx_len) @(posedge clk);
                #1;
                bus.i_Tx_Active = 1'b0;
                bus.i_Tx_Done   = 1'b1;
                done_cyc        = cyc;
                gap_pending     = (bus.o_Level != 0);
                @(posedge clk);
                #1 bus.i_Tx_Done = 1'b0;
            end
        end
    end

    task automatic push(input logic [7:0] b, input bit accept);
        @(posedge clk);
        #1;
        bus.i_Wr_En   = 1'b1;
        bus.i_Wr_Byte = b;
        if (accept) exp_q.push_back(b);
    endtask

    task automatic idle();
        @(posedge clk);
        #1 bus.i_Wr_En = 1'b0;
    endtask

    task automatic wait_dv(input int target, input int budget);
        for (int i = 0; i < budget && dv_cnt < target; i++) @(negedge clk);
        chk("wait_dv_reached", int'(dv_cnt >= target), 1);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (bus.o_Busy || exp_q.size() != 0); i++) @(negedge clk);
        chk("drain_busy", bus.o_Busy, 0);
        chk("drain_empty", bus.o_Empty, 1);
        chk("drain_level", bus.o_Level, 0);
        chk("drain_scoreboard", exp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dv"},    bus.o_Tx_DV, 0);
        chk({tag, "_byte"},  bus.o_Tx_Byte, 8'h00);
        chk({tag, "_full"},  bus.o_Full, 0);
        chk({tag, "_empty"}, bus.o_Empty, 1);
        chk({tag, "_level"}, bus.o_Level, 0);
        chk({tag, "_busy"},  bus.o_Busy, 0);
        chk({tag, "_ovf"},   bus.o_Overflow, 0);
    endtask

    initial begin
        int n;
        int rst_cyc;
        bus.i_Wr_En   = 1'b0;
        bus.i_Wr_Byte = 8'h00;
        bus.i_Ovf_Clr = 1'b0;

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single byte from an empty queue
        tx_len = 10;
        push(8'hA5, 1'b1);
        n = cyc + 1;
        idle();
        @(negedge clk);
        chk("single_empty_after_push", bus.o_Empty, 0);
        chk("single_level_after_push", bus.o_Level, 1);
        wait_dv(1, 20);
        chk("single_dv_cycle", last_dv_cyc, n + 1);
        wait_drain(60);

        // Burst of 16 behind a byte in flight fills the queue
        tx_len = 40;
        push(8'h5A, 1'b1);
        idle();
        wait_dv(2, 20);
        for (int i = 1; i <= 16; i++) push(8'(i), 1'b1);
        idle();
        @(negedge clk);
        chk("burst_full", bus.o_Full, 1);
        chk("burst_level", bus.o_Level, 16);

        // Push while full is dropped
        push(8'hEE, 1'b0);
        idle();
        @(negedge clk);
        chk("ovf_level_unchanged", bus.o_Level, 16);
        chk("ovf_flag_set", bus.o_Overflow, OVF_ON);
        @(posedge clk);
        #1 bus.i_Ovf_Clr = 1'b1;
        @(posedge clk);
        #1 bus.i_Ovf_Clr = 1'b0;
        @(negedge clk);
        chk("ovf_flag_cleared", bus.o_Overflow, 0);

        // Push on the edge the FSM pops from a full queue
        for (int i = 0; i < 80 && !bus.i_Tx_Done; i++) @(negedge clk);
        chk("same_cycle_done_seen", bus.i_Tx_Done, 1);
        push(8'hFF, 1'b0);
        idle();
        @(negedge clk);
        chk("same_cycle_level", bus.o_Level, 15);
        chk("same_cycle_ovf", bus.o_Overflow, OVF_ON);
        @(posedge clk);
        #1 bus.i_Ovf_Clr = 1'b1;
        tx_len = 4;
        @(posedge clk);
        #1 bus.i_Ovf_Clr = 1'b0;
        wait_drain(400);
        chk("burst_issue_count", dv_cnt, 18);

        // Pointer wrap: two rounds of 12 queued bytes
        for (int r = 0; r < 2; r++) begin
            tx_len = 30;
            push(8'h11 + 8'(r), 1'b1);
            idle();
            wait_dv(dv_cnt + 1, 20);
            for (int i = 0; i < 12; i++) push(8'h20 + 8'(r * 16) + 8'(i), 1'b1);
            idle();
            @(negedge clk);
            chk("wrap_level_12", bus.o_Level, 12);
            tx_len = 4;
            wait_drain(300);
        end
        chk("wrap_issue_count", dv_cnt, 44);

        // Reset while waiting for Done with 5 bytes queued
        tx_len = 30;
        push(8'h77, 1'b1);
        idle();
        wait_dv(45, 20);
        for (int i = 0; i < 5; i++) push(8'h81 + 8'(i), 1'b1);
        idle();
        @(negedge clk);
        chk("rst_mid_level", bus.o_Level, 5);
        chk("rst_mid_active", bus.i_Tx_Active, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rst_cyc = cyc;
        exp_q.delete();
        gap_pending = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("late_done_arrived", int'(done_cyc > rst_cyc), 1);
        chk("no_issue_after_reset", dv_cnt, 45);
        chk("post_reset_busy", bus.o_Busy, 0);
        chk("post_reset_empty", bus.o_Empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte queue and issue controller sitting directly upstream of the UART transmitter. Producers push bytes at clock rate. The block buffers them in a FIFO and hands them to the transmitter one at a time, using the transmitter's data-valid, active and done handshake. It decouples bursty writers, such as status and telemetry formatters, from the slow serial line.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- i_Clock  in  1  system clock; all logic on the rising edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Wr_En  in  1  push strobe; one byte per cycle.
- i_Wr_Byte  in  8  byte to push.
- o_Full  out  1  FIFO holds DEPTH bytes.
- o_Empty  out  1  FIFO holds 0 bytes.
- o_Level  out  ADDR_W+1  current fill count.
- o_Tx_DV  out  1  one-cycle issue strobe to the transmitter.
- o_Tx_Byte  out  8  byte presented with o_Tx_DV; held stable until the next issue.
- i_Tx_Active  in  1  transmitter busy flag.
- i_Tx_Done  in  1  transmitter one-cycle completion pulse.
- o_Busy  out  1  FSM not in S_IDLE, or FIFO not empty.
- i_Ovf_Clr  in  1  clears o_Overflow.
- o_Overflow  out  1  sticky flag for a dropped push.

## Operation
- FIFO:
  - Circular buffer with rd_ptr and wr_ptr (ADDR_W bits, natural wrap) and a count register (ADDR_W+1 bits).
  - Push is accepted when i_Wr_En=1 and the registered o_Full=0.
  - A push while o_Full=1 is dropped, even if a pop happens in the same cycle.
  - Count rules: push only → +1; pop only → −1; push and pop together → unchanged.
- FSM states: S_IDLE, S_ISSUE, S_WAIT_ACTIVE, S_WAIT_DONE.
  - S_IDLE: if count≠0, go to S_ISSUE. On that same edge, register o_Tx_Byte from the head entry and advance rd_ptr (the pop).
  - S_ISSUE: o_Tx_DV=1 for exactly this one cycle; go to S_WAIT_ACTIVE.
  - S_WAIT_ACTIVE: stay until i_Tx_Active=1, then go to S_WAIT_DONE.
  - S_WAIT_DONE: stay until i_Tx_Done=1, then go to S_IDLE.
  - An i_Tx_Done seen in S_WAIT_ACTIVE also returns the FSM to S_IDLE. This covers a byte that completes before Active is sampled.
- Only one byte is ever outstanding at the transmitter. The transmitter accepts o_Tx_DV only when it is idle, and this FSM guarantees that.
- Reset mid-operation:
  - Pointers, count and FSM clear immediately; queued bytes are lost.
  - A byte already being shifted out by the transmitter finishes; its Done pulse arrives in S_IDLE and is ignored.

## Timing
- Reset values:
  - o_Tx_DV=0, o_Tx_Byte=8'h00, o_Full=0, o_Empty=1, o_Level=0, o_Busy=0, o_Overflow=0.
  - FSM in S_IDLE; rd_ptr=wr_ptr=0.
- o_Full, o_Empty and o_Level are registered and reflect pushes and pops from the previous edge.
- Push into an empty queue at edge N: o_Empty falls after N; the FSM enters S_ISSUE at N+1; o_Tx_DV is high during cycle N+1..N+2.
- Back-to-back bytes: the next o_Tx_DV follows i_Tx_Done by 2 cycles (Done → S_IDLE → S_ISSUE).
- Wrap-around: after DEPTH pushes, wr_ptr returns to 0. Full and empty are distinguished only by count.

## Configuration
- UART_TX_QUEUE_OVF_EN defined:
  - A dropped push sets o_Overflow on the next edge.
  - o_Overflow stays set until i_Ovf_Clr=1.
  - If a drop and a clear happen in the same cycle, set wins.
- Undefined: o_Overflow is tied to 0 and i_Ovf_Clr is ignored. Drops still occur silently.

## Structure
- Shared package uart_pkg holds:
  - the FSM state typedef (2-bit encoding for S_IDLE, S_ISSUE, S_WAIT_ACTIVE, S_WAIT_DONE);
  - the default DEPTH constant;
  - the byte-width constant (8).
- Sub-module uart_tx_queue_mem: DEPTH×8 storage with synchronous write and asynchronous read at rd_ptr. It has no reset.

## Test plan
- Single byte: reset, push 8'hA5, model the transmitter (Active for 10 cycles, then Done). Expect one o_Tx_DV pulse at N+1 with o_Tx_Byte=8'hA5, and o_Empty=1 and o_Busy=0 after Done.
- Burst order: push 8'h01..8'h10 on consecutive cycles with DEPTH=16. Expect o_Full=1 after the 16th push, and exactly 16 issues in order 01..10 with each o_Tx_DV 2 cycles after the prior Done.
- Overflow: fill to 16, then push 8'hEE. Expect 8'hEE never issued and o_Overflow=1 (macro on) or 0 (macro off). Pulse i_Ovf_Clr and expect 0.
- Push while full with a same-cycle pop: push on the cycle the FSM leaves S_IDLE with count=16. Expect the push dropped and o_Level=15 afterward.
- Wrap: push 12, drain 12, push 12. Expect correct order across the pointer wrap and o_Level tracking 0→12→0→12.
- Reset mid-transfer: assert i_Reset_n=0 during S_WAIT_DONE with 5 queued. Expect all outputs at reset values, the late i_Tx_Done ignored, and no further o_Tx_DV.
